// File: rtl/buffered_uart_pkg.sv
// Shared state encodings and baud/counter sizing helpers for buffered_uart.
package buffered_uart_pkg;

  typedef logic [2:0] uartState_t;

  localparam uartState_t StIdle   = 3'd0;
  localparam uartState_t StStart  = 3'd1;
  localparam uartState_t StData   = 3'd2;
  localparam uartState_t StParity = 3'd3;
  localparam uartState_t StStop   = 3'd4;

  function automatic int cyclesPerBit(input int clockFreq, input int baudRate);
    return clockFreq / baudRate;
  endfunction

  // Width of a counter that must hold 0..count-1.
  function automatic int cntWidth(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/buffered_uart_if.sv
// Parallel-side handshake bundle of buffered_uart: TX push and RX pop.
interface buffered_uart_if #(parameter int DataWidth = 8);
  logic [DataWidth-1:0] DataIn;
  logic                 DataInValid;
  logic                 DataInReady;
  logic [DataWidth-1:0] DataOut;
  logic                 DataOutValid;
  logic                 DataOutReady;

  modport master (output DataIn, DataInValid, DataOutReady,
                  input  DataInReady, DataOut, DataOutValid);
  modport slave  (input  DataIn, DataInValid, DataOutReady,
                  output DataInReady, DataOut, DataOutValid);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; extra pointer bit separates full from empty.
module sync_fifo #(
  parameter int DataWidth = 8,
  parameter int FifoDepth = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DataWidth-1:0] wrData,
  input  logic                 wrEn,
  output logic                 full,
  output logic [DataWidth-1:0] rdData,
  input  logic                 rdEn,
  output logic                 empty
);
  localparam int AddrW = $clog2(FifoDepth);

  logic [DataWidth-1:0] mem [FifoDepth];
  logic [AddrW:0]       wrPtr, rdPtr;
  logic                 doRd, doWr;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AddrW] != rdPtr[AddrW]) &&
                  (wrPtr[AddrW-1:0] == rdPtr[AddrW-1:0]);
  assign doRd   = rdEn && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign doWr   = wrEn && (!full || doRd);
  assign rdData = mem[rdPtr[AddrW-1:0]];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (doWr) mem[wrPtr[AddrW-1:0]] <= wrData;
  end
endmodule

// File: rtl/buffered_uart.sv
// UART with TX/RX FIFOs. Define UART_PARITY_EN to add an even-parity bit per frame.
module buffered_uart
  import buffered_uart_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200,
  parameter int DataWidth = 8,
  parameter int FifoDepth = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  buffered_uart_if.slave    bus,
  input  logic              SIn,
  output logic              SOut,
  output logic              FramingError,
  output logic              ParityError,
  output logic              Overrun
);
  localparam int CyclesPerBit = cyclesPerBit(ClockFreq, BaudRate);
  localparam int CntW = cntWidth(CyclesPerBit);
  localparam int BitW = cntWidth(DataWidth);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CyclesPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CyclesPerBit / 2 - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DataWidth - 1);

  // ---------------- TX ----------------
  logic                 txFull, txEmpty, txPop;
  logic [DataWidth-1:0] txHead, txShift;
  uartState_t           txState;
  logic [CntW-1:0]      txCnt;
  logic [BitW-1:0]      txBit;
  logic                 txBitDone;
`ifdef UART_PARITY_EN
  logic                 txPar;
`endif

  sync_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth)) uTxFifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .wrData (bus.DataIn),
    .wrEn   (bus.DataInValid && !txFull),
    .full   (txFull),
    .rdData (txHead),
    .rdEn   (txPop),
    .empty  (txEmpty)
  );

  assign bus.DataInReady = !txFull;
  assign txBitDone = (txCnt == BitEnd);
  // Next word is pulled either from idle or at the last stop-bit cycle, giving gapless frames.
  assign txPop = !txEmpty && ((txState == StIdle) || (txState == StStop && txBitDone));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      txState <= StIdle;
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
      SOut    <= 1'b1;
`ifdef UART_PARITY_EN
      txPar   <= 1'b0;
`endif
    end else begin
      txCnt <= (txState == StIdle || txBitDone) ? '0 : txCnt + 1'b1;
      case (txState)
        StIdle, StStop: begin
          if (txState == StIdle || txBitDone) begin
            if (txPop) begin
              txState <= StStart;
              SOut    <= 1'b0;
              txShift <= txHead;
`ifdef UART_PARITY_EN
              txPar   <= ^txHead;
`endif
            end else begin
              txState <= StIdle;
              SOut    <= 1'b1;
            end
          end
        end
        StStart: begin
          if (txBitDone) begin
            txState <= StData;
            SOut    <= txShift[0];
            txShift <= txShift >> 1;
            txBit   <= '0;
          end
        end
        StData: begin
          if (txBitDone) begin
            if (txBit == LastBit) begin
`ifdef UART_PARITY_EN
              txState <= StParity;
              SOut    <= txPar;
`else
              txState <= StStop;
              SOut    <= 1'b1;
`endif
            end else begin
              SOut    <= txShift[0];
              txShift <= txShift >> 1;
              txBit   <= txBit + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (txBitDone) begin
            txState <= StStop;
            SOut    <= 1'b1;
          end
        end
`endif
        default: begin
          txState <= StIdle;
          SOut    <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- RX ----------------
  logic                 sinMeta, sinSync;
  uartState_t           rxState;
  logic [CntW-1:0]      rxCnt;
  logic [BitW-1:0]      rxBit;
  logic [DataWidth-1:0] rxShift;
  logic                 rxArmed, rxBitDone, rxHalfDone, rxParOk;
  logic                 rxEnq, rxFull, rxEmpty, rxDeq;
  logic                 framingQ, overrunQ;
`ifdef UART_PARITY_EN
  logic                 rxPar, parityQ;
  assign rxParOk = ((^rxShift) == rxPar);
`else
  assign rxParOk = 1'b1;
`endif

  // Synchroniser resets low so a freshly reset RX must see SIn high through both flops before arming.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sinMeta <= 1'b0;
      sinSync <= 1'b0;
    end else begin
      sinMeta <= SIn;
      sinSync <= sinMeta;
    end
  end

  assign rxBitDone  = (rxCnt == BitEnd);
  assign rxHalfDone = (rxCnt == HalfEnd);
  assign rxDeq      = bus.DataOutReady && !rxEmpty;
  assign rxEnq      = (rxState == StStop) && rxBitDone && sinSync && rxParOk;

  sync_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth)) uRxFifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .wrData (rxShift),
    .wrEn   (rxEnq),
    .full   (rxFull),
    .rdData (bus.DataOut),
    .rdEn   (bus.DataOutReady),
    .empty  (rxEmpty)
  );

  assign bus.DataOutValid = !rxEmpty;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rxState  <= StIdle;
      rxCnt    <= '0;
      rxBit    <= '0;
      rxShift  <= '0;
      rxArmed  <= 1'b0;
      framingQ <= 1'b0;
      overrunQ <= 1'b0;
`ifdef UART_PARITY_EN
      rxPar    <= 1'b0;
      parityQ  <= 1'b0;
`endif
    end else begin
      framingQ <= 1'b0;
      overrunQ <= 1'b0;
`ifdef UART_PARITY_EN
      parityQ  <= 1'b0;
`endif
      rxCnt <= rxCnt + 1'b1;
      case (rxState)
        StIdle: begin
          rxCnt <= '0;
          if (!rxArmed) rxArmed <= sinSync;
          else if (!sinSync) rxState <= StStart;
        end
        StStart: begin
          if (rxHalfDone) begin
            rxCnt   <= '0;
            rxBit   <= '0;
            rxState <= sinSync ? StIdle : StData;
          end
        end
        StData: begin
          if (rxBitDone) begin
            rxCnt   <= '0;
            rxShift <= {sinSync, rxShift[DataWidth-1:1]};
            if (rxBit == LastBit) begin
`ifdef UART_PARITY_EN
              rxState <= StParity;
`else
              rxState <= StStop;
`endif
            end else begin
              rxBit <= rxBit + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (rxBitDone) begin
            rxCnt   <= '0;
            rxPar   <= sinSync;
            rxState <= StStop;
          end
        end
`endif
        StStop: begin
          if (rxBitDone) begin
            rxCnt   <= '0;
            rxState <= StIdle;
            if (!sinSync) begin
              // Line may be held low (break); wait for it to return high before rearming.
              framingQ <= 1'b1;
              rxArmed  <= 1'b0;
            end else if (!rxParOk) begin
`ifdef UART_PARITY_EN
              parityQ  <= 1'b1;
`endif
            end else begin
              overrunQ <= rxFull && !rxDeq;
            end
          end
        end
        default: rxState <= StIdle;
      endcase
    end
  end

  assign FramingError = framingQ;
  assign Overrun      = overrunQ;
`ifdef UART_PARITY_EN
  assign ParityError  = parityQ;
`else
  assign ParityError  = 1'b0;
`endif
endmodule

// File: tb/tb_buffered_uart.sv
// Scoreboarded bench for buffered_uart at 10 cycles/bit; a line decoder checks TX frames.
module tb_buffered_uart;
  localparam int CPB = 10;
  localparam int DW  = 8;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = CPB * (DW + 2 + PB);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic loop = 1'b0;
  logic drvLine = 1'b1;
  logic sIn, sOut, framingError, parityError, overrun;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   feCnt = 0, peCnt = 0, ovCnt = 0, vldCnt = 0, popCnt = 0;
  logic [7:0] expQ[$];
  logic [DW:0] txLog[$];
  int   txStart[$];

  buffered_uart_if #(.DataWidth(DW)) bus ();

  assign sIn = loop ? sOut : drvLine;

  buffered_uart #(.ClockFreq(50_000_000), .BaudRate(5_000_000),
                  .DataWidth(DW), .FifoDepth(8)) dut (
    .Clock(clk), .Reset(rst), .bus(bus), .SIn(sIn), .SOut(sOut),
    .FramingError(framingError), .ParityError(parityError), .Overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RX scoreboard and error-pulse counters.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (framingError) feCnt++;
      if (parityError)  peCnt++;
      if (overrun)      ovCnt++;
      if (!rst && bus.DataOutValid) vldCnt++;
      if (!rst && bus.DataOutValid && bus.DataOutReady) begin
        popCnt++;
        if (expQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL rx_unexpected actual=%0h required=none", bus.DataOut);
        end else begin
          e = expQ.pop_front();
          check("rx_word", {24'd0, bus.DataOut}, {24'd0, e});
        end
      end
    end
  end

  // Independent decoder of the TX line: logs {stop, data} and start cycle.
  initial begin
    int st;
    logic [DW-1:0] d;
    logic stopB;
    forever begin
      @(negedge clk);
      if (!rst && sOut === 1'b0) begin
        st = cyc;
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = sOut;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
`endif
        repeat (CPB) @(negedge clk);
        stopB = sOut;
        txLog.push_back({stopB, d});
        txStart.push_back(st);
      end
    end
  end

  task automatic push(input logic [7:0] w);
    int k = 0;
    bus.DataIn = w;
    bus.DataInValid = 1'b1;
    @(negedge clk);
    while (!bus.DataInReady && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) begin
      checks++; failures++;
      $display("FAIL push_timeout actual=notready required=ready");
    end
    @(posedge clk); #1;
    bus.DataInValid = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    drvLine = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] w, input logic par, input logic stopB);
    sendBit(1'b0);
    for (int i = 0; i < DW; i++) sendBit(w[i]);
`ifdef UART_PARITY_EN
    sendBit(par);
`else
    if (par) drvLine = 1'b1;
`endif
    sendBit(stopB);
    drvLine = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic waitTx(input int n, input int budget);
    int k = 0;
    while (txLog.size() < n && k < budget) begin @(posedge clk); k++; end
    check("tx_frames_seen", txLog.size(), n);
  endtask

  task automatic waitRxDrain(input int budget);
    int k = 0;
    while (expQ.size() != 0 && k < budget) begin @(posedge clk); k++; end
    check("rx_drained", expQ.size(), 0);
  endtask

  logic [7:0] rxTab [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                             8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
  logic [7:0] txTab [9]  = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A,
                             8'hA5, 8'h3C, 8'hC3, 8'h96};

  initial begin
    int fe0, pe0, ov0, v0, p0, k;
    bus.DataIn = '0;
    bus.DataInValid = 1'b0;
    bus.DataOutReady = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sout", sOut, 1);
    check("rst_inready", bus.DataInReady, 1);
    check("rst_outvalid", bus.DataOutValid, 0);
    check("rst_errors", {framingError, parityError, overrun}, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Loopback of two words.
    loop = 1'b1;
    fe0 = feCnt; pe0 = peCnt; ov0 = ovCnt;
    txLog.delete(); txStart.delete();
    expQ.push_back(8'h6C); expQ.push_back(8'h77);
    push(8'h6C);
    push(8'h77);
    waitTx(2, 3 * FRAME);
    waitRxDrain(100);
    if (txLog.size() >= 2) begin
      check("loop_frame_len", txStart[1] - txStart[0], FRAME);
      check("loop_tx0", txLog[0], {1'b1, 8'h6C});
      check("loop_tx1", txLog[1], {1'b1, 8'h77});
    end
    check("loop_errors", (feCnt - fe0) + (peCnt - pe0) + (ovCnt - ov0), 0);
    repeat (20) @(posedge clk);
    #1 loop = 1'b0;

    // Nine words with the line busy: FIFO fills, frames stay gapless.
    txLog.delete(); txStart.delete();
    push(txTab[0]);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i < 9; i++) push(txTab[i]);
    check("full_inready_low", bus.DataInReady, 0);
    waitTx(9, 10 * FRAME);
    if (txLog.size() >= 9)
      for (int i = 0; i < 9; i++) begin
        check("b2b_word", txLog[i], {1'b1, txTab[i]});
        if (i > 0) check("b2b_gap", txStart[i] - txStart[i-1], FRAME);
      end
    check("b2b_inready_back", bus.DataInReady, 1);

    // Ten RX frames with no consumer: 8 held, 2 overruns.
    bus.DataOutReady = 1'b0;
    ov0 = ovCnt;
    for (int i = 0; i < 8; i++) expQ.push_back(rxTab[i]);
    for (int i = 0; i < 10; i++) sendFrame(rxTab[i], ^rxTab[i], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("ovr_count", ovCnt - ov0, 2);
    check("ovr_valid_held", bus.DataOutValid, 1);
    check("ovr_head", bus.DataOut, rxTab[0]);
    repeat (7) @(posedge clk);
    #1;
    check("ovr_head_stable", bus.DataOut, rxTab[0]);
    bus.DataOutReady = 1'b1;
    waitRxDrain(50);
    repeat (2) @(posedge clk);
    #1;
    check("ovr_empty_after", bus.DataOutValid, 0);

    // Framing error, then a short low glitch.
    fe0 = feCnt; v0 = vldCnt; p0 = popCnt;
    sendFrame(8'hA5, ^8'hA5, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("fe_count", feCnt - fe0, 1);
    drvLine = 1'b0;
    repeat (3) @(posedge clk);
    #1 drvLine = 1'b1;
    repeat (FRAME + 20) @(posedge clk);
    #1;
    check("fe_glitch_count", feCnt - fe0, 1);
    check("fe_no_word", popCnt - p0, 0);
    check("fe_no_valid", vldCnt - v0, 0);

    // Reset during data bit 3 of 8'hA5 (bit 3 is 0, so reset must force SOut high).
    txLog.delete(); txStart.delete();
    push(8'hA5);
    k = 0;
    while (sOut !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    check("rst_tx_started", sOut, 0);
    repeat (CPB * 4 + 3) @(negedge clk);
    check("rst_mid_bit3_low", sOut, 0);
    #3 rst = 1'b1;
    #1;
    check("rst_async_sout", sOut, 1);
    check("rst_async_inready", bus.DataInReady, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (FRAME + 20) @(posedge clk);
    #1;
    check("rst_line_idle", sOut, 1);
    txLog.delete(); txStart.delete();
    push(8'h3C);
    waitTx(1, 2 * FRAME);
    if (txLog.size() >= 1) check("rst_next_frame", txLog[0], {1'b1, 8'h3C});

`ifdef UART_PARITY_EN
    // Bad parity: 8'h03 has even parity 0, send 1.
    pe0 = peCnt; fe0 = feCnt; v0 = vldCnt;
    sendFrame(8'h03, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("par_count", peCnt - pe0, 1);
    check("par_no_fe", feCnt - fe0, 0);
    check("par_no_valid", vldCnt - v0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
